instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  - Fetch stage directly upstream of Instruction_Memory_BRAM: owns the PC, drives the BRAM word address, captures read_data.
//  - Delivers {pc, instr} to decode over a valid/ready handshake.
//  - Absorbs the BRAM's fixed 1-cycle synchronous read latency with a 2-entry buffer.
//  - Supports decode back-pressure and branch/jump redirects.
// PARAMETERS
//  RESET_PC   32'h0000_0000   byte PC fetched first after reset (bits [1:0] must be 0)
//  BUF_DEPTH  2               output buffer entries (fixed at 2; no other value supported)
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_addr       out  32  BRAM word address = {2'b00, fetch_pc[31:2]}
//  imem_rdata      in   32  BRAM read_data (reflects imem_addr sampled at previous edge)
//  out_valid       out  1   buffer head holds a valid instruction
//  out_ready       in   1   decode accepts head this cycle
//  out_pc          out  32  byte PC of head instruction
//  out_instr       out  32  head instruction word
//  redirect_valid  in   1   1-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   32  redirect target (byte address)
// BEHAVIOUR
//  - Reset (async assert): fetch_pc=RESET_PC, inflight=0, count=0.
//    Outputs: out_valid=0, out_pc=0, out_instr=0, imem_addr=RESET_PC>>2.
//  - fire = out_valid & out_ready. issue = !redirect_valid & (count + inflight - fire < 2).
//  - Issue at edge k:
//    - req_pc<=fetch_pc, inflight<=1, fetch_pc<=fetch_pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
//    - BRAM registers the address at edge k; imem_rdata is pushed {req_pc, imem_rdata} at edge k+1.
//  - No issue: fetch_pc and imem_addr hold; inflight<=0. BRAM still reads, but the result is discarded.
//  - Latency: first out_valid after 2nd rising edge following rst_n release.
//    - Steady state with out_ready=1: one instruction per cycle, PCs strictly +4.
//  - Buffer: FIFO of {pc,instr}; head drives out_pc/out_instr.
//    - Push and pop in the same edge allowed.
//    - count never exceeds 2 (guaranteed by the issue rule); no overflow or drop.
//  - Stall (out_ready=0): out_valid, out_pc, out_instr stable until fire; no instruction duplicated or lost.
//  - Empty: out_valid=0, out_pc/out_instr hold last values (don't-care).
//  - Redirect (highest priority), at that edge:
//    - count<=0, inflight<=0.
//    - fetch_pc<={redirect_pc[31:2],2'b00} (low bits ignored).
//    - A fire in the same cycle completes normally; redirect source owns the consequences.
//    - out_valid=0 the cycle after redirect.
//    - Target instruction presented after 2 further edges; no stale pre-redirect PC ever presented.
//    - Back-to-back redirects: last one wins.
//  - Reset mid-operation: all state cleared asynchronously, out_valid drops without waiting for clk.
//    Fetch resumes at RESET_PC.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds two output ports, both reset to 0, both wrap at 2^32, both clear on redirect? no (count through redirects).
//    - perf_fetched  out 32  increments on every fire.
//    - perf_stall    out 32  increments each cycle out_valid & !out_ready.
//  IF_PERF_CNT_EN undefined: counters and ports absent; all other behaviour identical.
// TESTING
//  - Reset: mem[0..2]=0x00000013,0x00100093,0x00200113, out_ready=1, release rst_n
//    -> out_valid rises after edge 2; (pc,instr)=(0,0x00000013),(4,0x00100093),(8,0x00200113) on consecutive cycles.
//  - Stall: hold out_ready=0 for 5 cycles while head pc=4
//    -> head stable, imem_addr stops once count+inflight=2; release -> pcs 4,8,C in order, none duplicated.
//  - Redirect: redirect_pc=0x10 with one fetch inflight, mem[4]=0xDEADBEEF
//    -> out_valid=0 next cycle, then (0x10,0xDEADBEEF) two edges later; pc 8 never shown.
//  - Misaligned/wrap: redirect_pc=0x13 -> out_pc=0x10.
//    redirect_pc=0xFFFF_FFFC -> next pc 0x0000_0000.
//  - Async reset mid-stream: assert rst_n=0 between edges -> out_valid=0 immediately; after release, first out_pc=RESET_PC.
//  - IF_PERF_CNT_EN: 3 fires and 2 stall cycles after reset -> perf_fetched=3, perf_stall=2.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage sitting directly in front of a synchronous-read instruction
//   BRAM. Owns the PC, drives the BRAM word address, captures the read data one
//   cycle later and hands {pc, instr} to decode over a valid/ready handshake.
//   A 2-entry output buffer absorbs the 1-cycle read latency so decode can
//   stall without losing or duplicating instructions. Redirects restart fetch.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr         BRAM word address ({2'b00, fetch_pc[31:2]})
//   imem_rdata        BRAM read data for the address sampled at the prior edge
//   out_valid/ready   handshake towards decode
//   out_pc/out_instr  byte PC and instruction word at the buffer head
//   redirect_valid    1-cycle pulse restarting fetch at redirect_pc
//   redirect_pc       redirect target (byte address, low two bits ignored)
//
// Optional feature macro: IF_PERF_CNT_EN
//   When defined, adds perf_fetched (fires) and perf_stall (cycles with
//   out_valid & !out_ready). Both 32-bit, wrap, reset only by rst_n.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
`ifdef IF_PERF_CNT_EN
    input  logic [31:0] redirect_pc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`else
    input  logic [31:0] redirect_pc
`endif
);

    localparam int unsigned WORD_W = 30;
    localparam int unsigned OCC_W  = 3;
    localparam logic [OCC_W-1:0] DEPTH_LIMIT = OCC_W'(BUF_DEPTH);

    // PCs are kept as word addresses; the byte-offset bits are always zero.
    logic [WORD_W-1:0] fetch_word_q, fetch_word_d;
    logic [WORD_W-1:0] req_word_q, req_word_d;
    logic              inflight_q, inflight_d;

    // Shift-style buffer: entry 0 is the head, entry 1 is behind it.
    logic              v0_q, v0_d, v1_q, v1_d;
    logic [WORD_W-1:0] b0_pc_q, b0_pc_d, b1_pc_q, b1_pc_d;
    logic [31:0]       b0_ins_q, b0_ins_d, b1_ins_q, b1_ins_d;

    logic              fire_c;
    logic              push_c;
    logic              issue_c;
    logic [OCC_W-1:0]  occ_c;
    logic              unused_low_bits_c;

    // Redirect target low bits are don't-care by definition.
    assign unused_low_bits_c = ^redirect_pc[1:0];

    assign fire_c = v0_q & out_ready;
    // Data returning this cycle is dropped if a redirect lands on this edge.
    assign push_c = inflight_q & ~redirect_valid;
    // Buffered + in-flight minus what leaves now must leave room for one more.
    assign occ_c  = OCC_W'(v0_q) + OCC_W'(v1_q) + OCC_W'(inflight_q) - OCC_W'(fire_c);
    assign issue_c = ~redirect_valid & (occ_c < DEPTH_LIMIT);

    // Next-state logic for PC, request tracking and output buffer.
    always_comb begin
        fetch_word_d = fetch_word_q;
        req_word_d   = req_word_q;
        inflight_d   = issue_c;
        v0_d         = v0_q;
        v1_d         = v1_q;
        b0_pc_d      = b0_pc_q;
        b0_ins_d     = b0_ins_q;
        b1_pc_d      = b1_pc_q;
        b1_ins_d     = b1_ins_q;

        if (issue_c) begin
            req_word_d   = fetch_word_q;
            fetch_word_d = fetch_word_q + WORD_W'(1);
        end

        if (redirect_valid) begin
            v0_d         = 1'b0;
            v1_d         = 1'b0;
            fetch_word_d = redirect_pc[31:2];
        end else if (fire_c) begin
            if (v1_q) begin
                b0_pc_d  = b1_pc_q;
                b0_ins_d = b1_ins_q;
                v0_d     = 1'b1;
                v1_d     = push_c;
                if (push_c) begin
                    b1_pc_d  = req_word_q;
                    b1_ins_d = imem_rdata;
                end
            end else begin
                v0_d = push_c;
                if (push_c) begin
                    b0_pc_d  = req_word_q;
                    b0_ins_d = imem_rdata;
                end
            end
        end else if (push_c) begin
            if (!v0_q) begin
                v0_d     = 1'b1;
                b0_pc_d  = req_word_q;
                b0_ins_d = imem_rdata;
            end else begin
                v1_d     = 1'b1;
                b1_pc_d  = req_word_q;
                b1_ins_d = imem_rdata;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_word_q <= RESET_PC[31:2];
            req_word_q   <= '0;
            inflight_q   <= 1'b0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            b0_pc_q      <= '0;
            b0_ins_q     <= '0;
            b1_pc_q      <= '0;
            b1_ins_q     <= '0;
        end else begin
            fetch_word_q <= fetch_word_d;
            req_word_q   <= req_word_d;
            inflight_q   <= inflight_d;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            b0_pc_q      <= b0_pc_d;
            b0_ins_q     <= b0_ins_d;
            b1_pc_q      <= b1_pc_d;
            b1_ins_q     <= b1_ins_d;
        end
    end

    assign imem_addr = {2'b00, fetch_word_q};
    assign out_valid = v0_q;
    assign out_pc    = {b0_pc_q, 2'b00};
    assign out_instr = b0_ins_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Performance counters run straight through redirects.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (fire_c) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (v0_q && !out_ready) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed bench with a BRAM model and an expected-fire scoreboard. Every
//   accepted instruction is compared against the queue of {pc, instr} pairs
//   the stimulus expects decode to receive, in order.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic [31:0] mem [64];
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .redirect_valid (redirect_valid),
`ifdef IF_PERF_CNT_EN
        .redirect_pc    (redirect_pc),
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`else
        .redirect_pc    (redirect_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read BRAM: 64 words, address aliased on the low bits.
    always @(posedge clk) imem_rdata <= mem[imem_addr[5:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_at(input logic [31:0] pc);
        return mem[pc[7:2]];
    endfunction

    task automatic expect_fire(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_at(pc);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a fire seen at negedge is accepted at the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pc", out_pc, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        mem[4] = 32'hDEAD_BEEF;

        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // First fetches and latency
        expect_fire(32'h0);
        expect_fire(32'h4);
        expect_fire(32'h8);
        rst_n = 1'b1;
        tick();                                      // E1
        chk("lat_e1_valid", 32'(out_valid), 32'd0);
        tick();                                      // E2
        chk("lat_e2_valid", 32'(out_valid), 32'd1);
        chk("lat_e2_pc", out_pc, 32'h0);
        tick();                                      // E3 fires 0
        tick();                                      // E4 fires 4
        tick();                                      // E5 fires 8, head C

        // Stall with head at 0xC
        out_ready = 1'b0;
        expect_fire(32'hC);
        expect_fire(32'h10);
        expect_fire(32'h14);
        for (int i = 0; i < 5; i++) begin
            tick();                                  // E6..E10
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_pc, 32'hC);
            chk("stall_instr", out_instr, mem_at(32'hC));
            chk("stall_addr", imem_addr, 32'h5);
        end
        out_ready = 1'b1;
        tick();                                      // E11 fires C
        tick();                                      // E12 fires 10

        // Redirect to 0x10 while 0x18 is in flight; head 0x14 still fires
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();                                      // E13
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("redir_valid_e1", 32'(out_valid), 32'd0);
        tick();
        chk("redir_valid_e2", 32'(out_valid), 32'd0);
        tick();
        chk("redir_valid_e3", 32'(out_valid), 32'd1);
        chk("redir_pc", out_pc, 32'h10);
        chk("redir_instr", out_instr, 32'hDEAD_BEEF);
        expect_fire(32'h10);
        out_ready = 1'b1;
        tick();                                      // E16 fires 10
        out_ready = 1'b0;

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("misal_valid", 32'(out_valid), 32'd1);
        chk("misal_pc", out_pc, 32'h10);
        chk("misal_instr", out_instr, 32'hDEAD_BEEF);

        // Wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 32'h3FFF_FFFF);
        chk("wrap_valid_off", 32'(out_valid), 32'd0);
        tick();
        tick();
        chk("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
        expect_fire(32'hFFFF_FFFC);
        expect_fire(32'h0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;

        // Back-to-back redirects: the second one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_pc    = 32'h20;
        tick();
        redirect_valid = 1'b0;
        chk("b2b_valid_e1", 32'(out_valid), 32'd0);
        tick();
        chk("b2b_valid_e2", 32'(out_valid), 32'd0);
        tick();
        chk("b2b_pc", out_pc, 32'h20);
        chk("b2b_instr", out_instr, mem_at(32'h20));

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        tick();
        tick();
        expect_fire(32'h0);
        expect_fire(32'h4);
        expect_fire(32'h8);
        rst_n = 1'b1;
        tick();                                      // E1
        tick();                                      // E2
        chk("arst_resume_pc", out_pc, 32'h0);
        tick();                                      // stall 1
        tick();                                      // stall 2
        out_ready = 1'b1;
        tick();                                      // fire 0
        tick();                                      // fire 4
        tick();                                      // fire 8
        out_ready = 1'b0;
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'd3);
        chk("perf_stall", perf_stall, 32'd2);
`endif
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
